node_port: RTL and testbench

//  Node-side endpoint of the router_core node interface: queues host packets, offers them to the core,
//  and captures packets the core delivers. Sits between host logic and one router core on Clk_R.

---
 rtl/node_port_pkg.sv | 18 +
 rtl/node_port_if.sv | 31 +++
 rtl/node_port_fifo.sv | 49 ++++
 rtl/node_port.sv | 155 +++++++++++++++
 tb/tb_node_port.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_port_pkg.sv
// Shared widths, send FSM state encoding and the saturating wait-counter helper for node_port.
package node_port_pkg;

  localparam int NODE_TX_W = 29;
  localparam int NODE_RX_W = 24;
  localparam int TO_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } send_state_t;

  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/node_port_if.sv
// Host-side queue handshakes plus the router-core node link; slave is the node_port view.
interface node_port_if;
  import node_port_pkg::*;

  logic [NODE_TX_W-1:0] host_tx_data;
  logic                 host_tx_valid;
  logic                 host_tx_ready;
  logic [NODE_RX_W-1:0] host_rx_data;
  logic                 host_rx_valid;
  logic                 host_rx_ready;
  logic [NODE_TX_W-1:0] Packet_From_Node;
  logic                 Packet_From_Node_Valid;
  logic                 Core_Load_Ack;
  logic [NODE_RX_W-1:0] Packet_To_Node;
  logic                 Packet_To_Node_Valid;

  modport slave (
    input  host_tx_data, host_tx_valid, host_rx_ready,
    input  Core_Load_Ack, Packet_To_Node, Packet_To_Node_Valid,
    output host_tx_ready, host_rx_data, host_rx_valid,
    output Packet_From_Node, Packet_From_Node_Valid
  );

  modport master (
    output host_tx_data, host_tx_valid, host_rx_ready,
    output Core_Load_Ack, Packet_To_Node, Packet_To_Node_Valid,
    input  host_tx_ready, host_rx_data, host_rx_valid,
    input  Packet_From_Node, Packet_From_Node_Valid
  );

endinterface

// File: rtl/node_port_fifo.sv
// node_fifo: synchronous WIDTH x DEPTH FIFO (DEPTH power of 2); head is the registered read slot.
// Push while full and pop while empty are ignored; push and pop in the same cycle are both taken.
module node_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; empty gating in the parent hides stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/node_port.sv
// node_port: host send/receive queues bridged to one router core node link (offer/ack out, pulse in).
// Optional per-port statistics counters are enabled with NODE_PORT_STATS_EN.
module node_port
  import node_port_pkg::*;
#(
  parameter int TXQ_DEPTH   = 4,
  parameter int RXQ_DEPTH   = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       Clk_R,
  input  logic       Rst_n,
  node_port_if.slave bus,
  output logic       rx_overflow,
  output logic       ack_timeout
`ifdef NODE_PORT_STATS_EN
  ,
  output logic [7:0] stat_sent,
  output logic [7:0] stat_rcvd,
  output logic [7:0] stat_drop
`endif
);

  localparam int TXC_W = $clog2(TXQ_DEPTH) + 1;
  localparam int RXC_W = $clog2(RXQ_DEPTH) + 1;
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(ACK_TIMEOUT);

  send_state_t          state;
  logic [TO_CNT_W-1:0]  wait_cnt;
  logic [NODE_TX_W-1:0] pfn_data;
  logic                 pfn_valid;
  logic                 tx_ready_q;

  logic [NODE_TX_W-1:0] tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic [TXC_W-1:0]     tx_count;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_full_next;

  logic [NODE_RX_W-1:0] rx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic [RXC_W-1:0]     rx_count;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_drop;

  assign tx_push = bus.host_tx_valid && tx_ready_q;
  assign tx_pop  = (state == OFFER) && bus.Core_Load_Ack;

  node_fifo #(.WIDTH(NODE_TX_W), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk       (Clk_R),
    .rst_n     (Rst_n),
    .push      (tx_push),
    .push_data (bus.host_tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Ready is registered from the next-cycle fill level so an ack never reaches it combinationally.
  always_comb begin
    tx_full_next = (tx_full && !tx_pop) ||
                   ((tx_count == TXC_W'(TXQ_DEPTH - 1)) && tx_push && !tx_pop);
  end

  always_ff @(posedge Clk_R) begin
    if (!Rst_n) tx_ready_q <= 1'b0;
    else        tx_ready_q <= !tx_full_next;
  end

  always_ff @(posedge Clk_R) begin
    if (!Rst_n) begin
      state       <= IDLE;
      pfn_valid   <= 1'b0;
      pfn_data    <= '0;
      wait_cnt    <= '0;
      ack_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            state     <= OFFER;
            pfn_valid <= 1'b1;
            pfn_data  <= tx_head;
            wait_cnt  <= '0;
          end
        end
        OFFER: begin
          if (bus.Core_Load_Ack) begin
            state     <= GAP;
            pfn_valid <= 1'b0;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (sat_inc(wait_cnt) >= TO_LIMIT) ack_timeout <= 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          pfn_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.host_tx_ready          = tx_ready_q;
  assign bus.Packet_From_Node       = pfn_data;
  assign bus.Packet_From_Node_Valid = pfn_valid;

  // Fullness is judged before this cycle's host pop, so a pop cannot rescue a pulse into a full queue.
  assign rx_push = bus.Packet_To_Node_Valid && !rx_full;
  assign rx_drop = bus.Packet_To_Node_Valid && rx_full;
  assign rx_pop  = bus.host_rx_ready && !rx_empty;

  node_fifo #(.WIDTH(NODE_RX_W), .DEPTH(RXQ_DEPTH)) u_rxq (
    .clk       (Clk_R),
    .rst_n     (Rst_n),
    .push      (rx_push),
    .push_data (bus.Packet_To_Node),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign bus.host_rx_valid = (rx_count != '0);
  assign bus.host_rx_data  = rx_empty ? '0 : rx_head;

  always_ff @(posedge Clk_R) begin
    if (!Rst_n)       rx_overflow <= 1'b0;
    else if (rx_drop) rx_overflow <= 1'b1;
  end

`ifdef NODE_PORT_STATS_EN
  always_ff @(posedge Clk_R) begin
    if (!Rst_n) begin
      stat_sent <= '0;
      stat_rcvd <= '0;
      stat_drop <= '0;
    end else begin
      if (tx_pop)  stat_sent <= stat_sent + 1'b1;
      if (rx_push) stat_rcvd <= stat_rcvd + 1'b1;
      if (rx_drop) stat_drop <= stat_drop + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_node_port.sv
// Randomised and directed bench for node_port against a queue-level reference model.
module tb_node_port;
  import node_port_pkg::*;

  localparam int DEPTH = 4;

  logic Clk_R = 1'b0;
  logic Rst_n = 1'b0;
  logic rx_overflow;
  logic ack_timeout;
`ifdef NODE_PORT_STATS_EN
  logic [7:0] stat_sent, stat_rcvd, stat_drop;
`endif

  node_port_if bus ();

  node_port #(.TXQ_DEPTH(DEPTH), .RXQ_DEPTH(DEPTH), .ACK_TIMEOUT(255)) dut (
    .Clk_R       (Clk_R),
    .Rst_n       (Rst_n),
    .bus         (bus),
    .rx_overflow (rx_overflow),
    .ack_timeout (ack_timeout)
`ifdef NODE_PORT_STATS_EN
    ,
    .stat_sent   (stat_sent),
    .stat_rcvd   (stat_rcvd),
    .stat_drop   (stat_drop)
`endif
  );

  always #5 Clk_R = ~Clk_R;

  int checks = 0;
  int errors = 0;

  // Reference model: packets waiting to be acked, packets waiting for the host, sticky flags.
  logic [NODE_TX_W-1:0] txq[$];
  logic [NODE_RX_W-1:0] rxq[$];
  bit m_ovf, m_to;
  int m_wait, m_sent, m_rcvd, m_drop;

  task automatic tick();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic drive_idle();
    bus.host_tx_data         = '0;
    bus.host_tx_valid        = 1'b0;
    bus.host_rx_ready        = 1'b0;
    bus.Core_Load_Ack        = 1'b0;
    bus.Packet_To_Node       = '0;
    bus.Packet_To_Node_Valid = 1'b0;
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_ovf = 0; m_to = 0; m_wait = 0; m_sent = 0; m_rcvd = 0; m_drop = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    Rst_n = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    model_clear();
  endtask

  // Advance one clock, applying the current inputs to the model first.
  task automatic cycle();
    bit pushed = bus.host_tx_valid && bus.host_tx_ready;
    bit acked  = bus.Core_Load_Ack && bus.Packet_From_Node_Valid;
    int s      = rxq.size();
    if (bus.Packet_From_Node_Valid && !acked) begin
      m_wait++;
      if (m_wait >= 255) m_to = 1;
    end else begin
      m_wait = 0;
    end
    if (acked && txq.size() > 0) begin
      void'(txq.pop_front());
      m_sent++;
    end
    if (pushed) txq.push_back(bus.host_tx_data);
    if (bus.host_rx_ready && s > 0) void'(rxq.pop_front());
    if (bus.Packet_To_Node_Valid) begin
      if (s < DEPTH) begin
        rxq.push_back(bus.Packet_To_Node);
        m_rcvd++;
      end else begin
        m_ovf = 1;
        m_drop++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    Rst_n = 1'b0;
    bus.host_tx_valid        = 1'b1;
    bus.host_tx_data         = 29'h0AAAAAAA;
    bus.Packet_To_Node_Valid = 1'b1;
    bus.Packet_To_Node       = 24'h55AA55;
    bus.Core_Load_Ack        = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.host_tx_ready, bus.host_rx_valid, bus.Packet_From_Node_Valid, rx_overflow, ack_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.host_tx_ready, bus.host_rx_valid, bus.Packet_From_Node_Valid, rx_overflow, ack_timeout});
    end
    checks++;
    if (bus.Packet_From_Node !== '0) begin
      errors++;
      $display("FAIL reset_pfn_data: got %h want 0", bus.Packet_From_Node);
    end
    drive_idle();
    Rst_n = 1'b1;
    model_clear();
    tick();
    checks++;
    if (bus.host_tx_ready !== 1'b1 || bus.Packet_From_Node_Valid !== 1'b0 || bus.host_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b rxv=%b want 1 0 0",
               bus.host_tx_ready, bus.Packet_From_Node_Valid, bus.host_rx_valid);
    end
`ifdef NODE_PORT_STATS_EN
    checks++;
    if ({stat_sent, stat_rcvd, stat_drop} !== 24'h0) begin
      errors++;
      $display("FAIL reset_stats: got %h %h %h want 0", stat_sent, stat_rcvd, stat_drop);
    end
`endif
  endtask

  task automatic test_single_offer();
    int n;
    do_reset();
    tick();
    bus.host_tx_valid = 1'b1;
    bus.host_tx_data  = 29'h1ABCDEF0;
    cycle();
    bus.host_tx_valid = 1'b0;
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: got valid=%b want 0", bus.Packet_From_Node_Valid);
    end
    cycle();
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b1 || bus.Packet_From_Node !== 29'h1ABCDEF0) begin
      errors++;
      $display("FAIL single_offer: got valid=%b data=%h want 1 1abcdef0",
               bus.Packet_From_Node_Valid, bus.Packet_From_Node);
    end
    cycle();
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b1 || bus.Packet_From_Node !== 29'h1ABCDEF0) begin
      errors++;
      $display("FAIL single_hold: got valid=%b data=%h want 1 1abcdef0",
               bus.Packet_From_Node_Valid, bus.Packet_From_Node);
    end
    bus.Core_Load_Ack = 1'b1;
    cycle();
    bus.Core_Load_Ack = 1'b0;
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: got valid=%b want 0", bus.Packet_From_Node_Valid);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (bus.Packet_From_Node_Valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL single_no_reoffer: got %0d valid cycles want 0", n);
    end
  endtask

  task automatic test_tx_fill();
    logic [NODE_TX_W-1:0] v [5];
    int idx, n;
    do_reset();
    tick();
    v[0] = 29'h1ABCDEF0;
    for (int i = 1; i < 5; i++) v[i] = NODE_TX_W'($urandom);
    idx = 0;
    bus.host_tx_valid = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bus.host_tx_data = v[idx];
      if (bus.host_tx_ready) idx++;
      cycle();
    end
    bus.host_tx_data = v[4];
    checks++;
    if (bus.host_tx_ready !== 1'b0 || idx != 4) begin
      errors++;
      $display("FAIL fill_ready_low: got ready=%b pushed=%0d want 0 4", bus.host_tx_ready, idx);
    end
    cycle();
    cycle();
    checks++;
    if (bus.host_tx_ready !== 1'b0 || bus.Packet_From_Node_Valid !== 1'b1 || bus.Packet_From_Node !== v[0]) begin
      errors++;
      $display("FAIL fill_hold: got ready=%b valid=%b data=%h want 0 1 %h",
               bus.host_tx_ready, bus.Packet_From_Node_Valid, bus.Packet_From_Node, v[0]);
    end
    bus.Core_Load_Ack = 1'b1;
    cycle();
    bus.Core_Load_Ack = 1'b0;
    checks++;
    if (bus.host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready_after_ack: got %b want 1", bus.host_tx_ready);
    end
    cycle();
    bus.host_tx_valid = 1'b0;
    n = 1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      bus.Core_Load_Ack = 1'b0;
      if (bus.Packet_From_Node_Valid) begin
        checks++;
        if (bus.Packet_From_Node !== v[n]) begin
          errors++;
          $display("FAIL fill_order[%0d]: got %h want %h", n, bus.Packet_From_Node, v[n]);
        end
        bus.Core_Load_Ack = 1'b1;
        n++;
      end
      cycle();
    end
    bus.Core_Load_Ack = 1'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL fill_drain_count: got %0d offers want 5", n);
    end
  endtask

  task automatic test_rx_basic();
    do_reset();
    tick();
    bus.Packet_To_Node_Valid = 1'b1;
    bus.Packet_To_Node       = 24'h123456;
    cycle();
    checks++;
    if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== 24'h123456) begin
      errors++;
      $display("FAIL rx_latency: got valid=%b data=%h want 1 123456", bus.host_rx_valid, bus.host_rx_data);
    end
    bus.Packet_To_Node = 24'h654321;
    cycle();
    bus.Packet_To_Node_Valid = 1'b0;
    cycle();
    checks++;
    if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== 24'h123456) begin
      errors++;
      $display("FAIL rx_head: got valid=%b data=%h want 1 123456", bus.host_rx_valid, bus.host_rx_data);
    end
    bus.host_rx_ready = 1'b1;
    cycle();
    checks++;
    if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== 24'h654321) begin
      errors++;
      $display("FAIL rx_second: got valid=%b data=%h want 1 654321", bus.host_rx_valid, bus.host_rx_data);
    end
    cycle();
    bus.host_rx_ready = 1'b0;
    checks++;
    if (bus.host_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_empty: got valid=%b want 0", bus.host_rx_valid);
    end
  endtask

  task automatic test_rx_overflow();
    logic [NODE_RX_W-1:0] d [5];
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) d[i] = NODE_RX_W'($urandom);
    bus.Packet_To_Node_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Packet_To_Node = d[i];
      cycle();
    end
    checks++;
    if (rx_overflow !== 1'b0 || bus.host_rx_data !== d[0]) begin
      errors++;
      $display("FAIL ovf_fill: got ovf=%b head=%h want 0 %h", rx_overflow, bus.host_rx_data, d[0]);
    end
    bus.Packet_To_Node = d[4];
    bus.host_rx_ready  = 1'b1;
    cycle();
    bus.Packet_To_Node_Valid = 1'b0;
    bus.host_rx_ready        = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", rx_overflow);
    end
`ifdef NODE_PORT_STATS_EN
    checks++;
    if (stat_drop !== 8'd1 || stat_rcvd !== 8'd4) begin
      errors++;
      $display("FAIL ovf_stats: got drop=%0d rcvd=%0d want 1 4", stat_drop, stat_rcvd);
    end
`endif
    bus.host_rx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== d[i]) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got valid=%b data=%h want 1 %h", i, bus.host_rx_valid, bus.host_rx_data, d[i]);
      end
      cycle();
    end
    bus.host_rx_ready = 1'b0;
    checks++;
    if (bus.host_rx_valid !== 1'b0 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped_gone: got valid=%b ovf=%b want 0 1", bus.host_rx_valid, rx_overflow);
    end
  endtask

  task automatic test_timeout();
    logic [NODE_TX_W-1:0] p;
    int w;
    do_reset();
    tick();
    p = NODE_TX_W'($urandom);
    bus.host_tx_valid = 1'b1;
    bus.host_tx_data  = p;
    cycle();
    bus.host_tx_valid = 1'b0;
    w = 0;
    while (!bus.Packet_From_Node_Valid && w < 10) begin
      cycle();
      w++;
    end
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b1) begin
      errors++;
      $display("FAIL to_offer_seen: got valid=%b want 1", bus.Packet_From_Node_Valid);
    end
    for (int k = 1; k <= 255; k++) begin
      cycle();
      if (k == 254) begin
        checks++;
        if (ack_timeout !== 1'b0) begin
          errors++;
          $display("FAIL to_early: got %b want 0 at cycle 254", ack_timeout);
        end
      end
    end
    checks++;
    if (ack_timeout !== 1'b1 || bus.Packet_From_Node_Valid !== 1'b1 || bus.Packet_From_Node !== p) begin
      errors++;
      $display("FAIL to_set: got to=%b valid=%b data=%h want 1 1 %h",
               ack_timeout, bus.Packet_From_Node_Valid, bus.Packet_From_Node, p);
    end
    bus.Core_Load_Ack = 1'b1;
    cycle();
    bus.Core_Load_Ack = 1'b0;
    cycle();
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b0 || ack_timeout !== 1'b1 || bus.host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_after_ack: got valid=%b to=%b rdy=%b want 0 1 1",
               bus.Packet_From_Node_Valid, ack_timeout, bus.host_tx_ready);
    end
  endtask

  task automatic test_reset_mid_offer();
    int n;
    do_reset();
    tick();
    bus.host_tx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.host_tx_data = NODE_TX_W'($urandom);
      cycle();
    end
    bus.host_tx_valid        = 1'b0;
    bus.Packet_To_Node_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.Packet_To_Node = NODE_RX_W'($urandom);
      cycle();
    end
    bus.Packet_To_Node_Valid = 1'b0;
    checks++;
    if (bus.Packet_From_Node_Valid !== 1'b1 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got valid=%b ovf=%b want 1 1", bus.Packet_From_Node_Valid, rx_overflow);
    end
    Rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.Packet_From_Node_Valid, bus.host_rx_valid, bus.host_tx_ready, rx_overflow, ack_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b want 00000",
               {bus.Packet_From_Node_Valid, bus.host_rx_valid, bus.host_tx_ready, rx_overflow, ack_timeout});
    end
    Rst_n = 1'b1;
    model_clear();
    bus.Core_Load_Ack = 1'b1;
    tick();
    bus.Core_Load_Ack = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Packet_From_Node_Valid || bus.host_rx_valid) n++;
      cycle();
    end
    checks++;
    if (n != 0 || bus.host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: got %0d stale valid cycles rdy=%b want 0 1", n, bus.host_tx_ready);
    end
  endtask

  task automatic test_random();
    int low_run;
    bit prev_vld;
    do_reset();
    tick();
    low_run  = 2;
    prev_vld = 0;
    for (int c = 0; c < 2000; c++) begin
      checks++;
      if (bus.host_tx_ready !== (txq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.host_tx_ready, txq.size() < DEPTH);
      end
      checks++;
      if (bus.host_rx_valid !== (rxq.size() > 0)) begin
        errors++;
        $display("FAIL rnd_rx_valid c%0d: got %b want %b", c, bus.host_rx_valid, rxq.size() > 0);
      end
      if (rxq.size() > 0) begin
        checks++;
        if (bus.host_rx_data !== rxq[0]) begin
          errors++;
          $display("FAIL rnd_rx_data c%0d: got %h want %h", c, bus.host_rx_data, rxq[0]);
        end
      end
      if (bus.Packet_From_Node_Valid) begin
        checks++;
        if (txq.size() == 0 || bus.Packet_From_Node !== txq[0]) begin
          errors++;
          $display("FAIL rnd_offer c%0d: got %h want queue head (size %0d)", c, bus.Packet_From_Node, txq.size());
        end
        if (!prev_vld) begin
          checks++;
          if (low_run < 2) begin
            errors++;
            $display("FAIL rnd_spacing c%0d: got %0d idle cycles want >=2", c, low_run);
          end
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_vld = bus.Packet_From_Node_Valid;
      checks++;
      if (rx_overflow !== m_ovf || ack_timeout !== m_to) begin
        errors++;
        $display("FAIL rnd_flags c%0d: got ovf=%b to=%b want %b %b", c, rx_overflow, ack_timeout, m_ovf, m_to);
      end
      bus.host_tx_valid        = ($urandom_range(1) == 1);
      bus.host_tx_data         = NODE_TX_W'($urandom);
      bus.Core_Load_Ack        = ($urandom_range(2) == 0);
      bus.Packet_To_Node_Valid = ($urandom_range(1) == 1);
      bus.Packet_To_Node       = NODE_RX_W'($urandom);
      bus.host_rx_ready        = ($urandom_range(2) == 0);
      cycle();
    end
    drive_idle();
`ifdef NODE_PORT_STATS_EN
    checks++;
    if (stat_sent !== 8'(m_sent) || stat_rcvd !== 8'(m_rcvd) || stat_drop !== 8'(m_drop)) begin
      errors++;
      $display("FAIL rnd_stats: got %0d %0d %0d want %0d %0d %0d",
               stat_sent, stat_rcvd, stat_drop, 8'(m_sent), 8'(m_rcvd), 8'(m_drop));
    end
`endif
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_offer();
    test_tx_fill();
    test_rx_basic();
    test_rx_overflow();
    test_timeout();
    test_reset_mid_offer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
